// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decoders, immediate extender, 32x32 register file
// with write-first bypass, and the ID/EX pipeline register that feeds execute.
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              InstrD,
  input  logic [XLEN-1:0]          PCD,
  input  logic [XLEN-1:0]          PCPlus4D,
  input  logic                     RegWriteW,
  input  logic [$clog2(NREGS)-1:0] RDW,
  input  logic [XLEN-1:0]          ResultW,
  input  logic                     FlushE,
  output logic                     RegWriteE,
  output logic                     ResultSrcE,
  output logic                     MemWriteE,
  output logic                     BranchE,
  output logic                     ALUSrcE,
  output logic [2:0]               ALUControlE,
  output logic [XLEN-1:0]          RD1E,
  output logic [XLEN-1:0]          RD2E,
  output logic [XLEN-1:0]          ImmExtE,
  output logic [$clog2(NREGS)-1:0] RS1E,
  output logic [$clog2(NREGS)-1:0] RS2E,
  output logic [$clog2(NREGS)-1:0] RDE,
  output logic [XLEN-1:0]          PCE,
  output logic [XLEN-1:0]          PCPlus4E
);

  localparam int AW = $clog2(NREGS);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B
  } immSrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluOp_e;

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [AW-1:0]  rs1Idx;
  logic [AW-1:0]  rs2Idx;
  logic [AW-1:0]  rdIdx;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1Idx = InstrD[19:15];
  assign rs2Idx = InstrD[24:20];
  assign rdIdx  = InstrD[11:7];

  logic     regWrite;
  logic     resultSrc;
  logic     memWrite;
  logic     branch;
  logic     aluSrc;
  immSrc_e  immSrc;
  aluOp_e   aluOp;
  logic     isRType;

  // Unknown opcodes decode to a bubble: every control left at its default.
  always_comb begin
    regWrite  = 1'b0;
    resultSrc = 1'b0;
    memWrite  = 1'b0;
    branch    = 1'b0;
    aluSrc    = 1'b0;
    immSrc    = IMM_NONE;
    aluOp     = ALUOP_ADD;
    isRType   = 1'b0;
    case (opcode)
      OP_LW: begin
        regWrite  = 1'b1;
        resultSrc = 1'b1;
        aluSrc    = 1'b1;
        immSrc    = IMM_I;
      end
      OP_SW: begin
        memWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = IMM_S;
      end
      OP_R: begin
        regWrite = 1'b1;
        aluOp    = ALUOP_FUNCT;
        isRType  = 1'b1;
      end
      OP_IALU: begin
        regWrite = 1'b1;
        aluSrc   = 1'b1;
        immSrc   = IMM_I;
        aluOp    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        branch = 1'b1;
        immSrc = IMM_B;
        aluOp  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  logic [2:0] aluControl;

  // Bit 30 selects sub only for R-type; for addi it is part of the immediate.
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  aluControl = (isRType && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

  logic [XLEN-1:0] immExt;

  always_comb begin
    immExt = '0;
    case (immSrc)
      IMM_I: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: immExt = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: immExt = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                       InstrD[30:25], InstrD[11:8], 1'b0};
      default: immExt = '0;
    endcase
  end

  // x0 has no storage; only entries 1..NREGS-1 exist.
  logic [XLEN-1:0] regs_q [1:NREGS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWriteW && (RDW != '0)) begin
      regs_q[RDW] <= ResultW;
    end
  end

  logic            bypassOk;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  assign bypassOk = RegWriteW && (RDW != '0);

  // Write-first: a same-cycle writeback to a read index is forwarded.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1Idx != '0) begin
      rd1 = (bypassOk && (RDW == rs1Idx)) ? ResultW : regs_q[rs1Idx];
    end
    if (rs2Idx != '0) begin
      rd2 = (bypassOk && (RDW == rs2Idx)) ? ResultW : regs_q[rs2Idx];
    end
  end

  logic            regWrite_q,  regWrite_d;
  logic            resultSrc_q, resultSrc_d;
  logic            memWrite_q,  memWrite_d;
  logic            branch_q,    branch_d;
  logic            aluSrc_q,    aluSrc_d;
  logic [2:0]      aluControl_q, aluControl_d;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [AW-1:0]   rs1_q, rs1_d;
  logic [AW-1:0]   rs2_q, rs2_d;
  logic [AW-1:0]   rd_q,  rd_d;
  logic [XLEN-1:0] pc_q,  pc_d;
  logic [XLEN-1:0] pcPlus4_q, pcPlus4_d;

  // A flush squashes only the controls; data/index/PC fields still advance.
  always_comb begin
    regWrite_d   = regWrite;
    resultSrc_d  = resultSrc;
    memWrite_d   = memWrite;
    branch_d     = branch;
    aluSrc_d     = aluSrc;
    aluControl_d = aluControl;
    rd1_d        = rd1;
    rd2_d        = rd2;
    imm_d        = immExt;
    rs1_d        = rs1Idx;
    rs2_d        = rs2Idx;
    rd_d         = rdIdx;
    pc_d         = PCD;
    pcPlus4_d    = PCPlus4D;
    if (FlushE) begin
      regWrite_d   = 1'b0;
      resultSrc_d  = 1'b0;
      memWrite_d   = 1'b0;
      branch_d     = 1'b0;
      aluSrc_d     = 1'b0;
      aluControl_d = 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite_q   <= 1'b0;
      resultSrc_q  <= 1'b0;
      memWrite_q   <= 1'b0;
      branch_q     <= 1'b0;
      aluSrc_q     <= 1'b0;
      aluControl_q <= 3'b000;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      pc_q         <= '0;
      pcPlus4_q    <= '0;
    end else begin
      regWrite_q   <= regWrite_d;
      resultSrc_q  <= resultSrc_d;
      memWrite_q   <= memWrite_d;
      branch_q     <= branch_d;
      aluSrc_q     <= aluSrc_d;
      aluControl_q <= aluControl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      pcPlus4_q    <= pcPlus4_d;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign RegWriteE   = rst & regWrite_q;
  assign ResultSrcE  = rst & resultSrc_q;
  assign MemWriteE   = rst & memWrite_q;
  assign BranchE     = rst & branch_q;
  assign ALUSrcE     = rst & aluSrc_q;
  assign ALUControlE = rst ? aluControl_q : 3'b000;
  assign RD1E        = rst ? rd1_q : '0;
  assign RD2E        = rst ? rd2_q : '0;
  assign ImmExtE     = rst ? imm_q : '0;
  assign RS1E        = rst ? rs1_q : '0;
  assign RS2E        = rst ? rs2_q : '0;
  assign RDE         = rst ? rd_q : '0;
  assign PCE         = rst ? pc_q : '0;
  assign PCPlus4E    = rst ? pcPlus4_q : '0;

endmodule

// File: tb/tb_decode_cycle.sv
// Bench for decode_cycle: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] InstrD = 32'h0;
  logic [31:0] PCD = 32'h0;
  logic [31:0] PCPlus4D = 32'h4;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RDW = 5'd0;
  logic [31:0] ResultW = 32'h0;
  logic        FlushE = 1'b0;

  logic        RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  int total = 0;
  int bad = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .RS1E(RS1E), .RS2E(RS2E),
    .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        regWrite;
    logic        resultSrc;
    logic        memWrite;
    logic        branch;
    logic        aluSrc;
    logic [2:0]  aluCtl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } idex_t;

  idex_t       expQ = '0;
  logic [31:0] mRegs [32];

  function automatic logic [31:0] modelRead(input logic [4:0] idx, input logic wEn,
                                            input logic [4:0] wAddr, input logic [31:0] wData);
    if (idx == 5'd0) return 32'h0;
    if (wEn && wAddr == idx) return wData;
    return mRegs[idx];
  endfunction

  // What ID/EX must hold after an edge, from the instruction set's rules.
  function automatic idex_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] pcp4, input logic flush,
                                    input logic wEn, input logic [4:0] wAddr,
                                    input logic [31:0] wData);
    idex_t p;
    logic [6:0] op;
    int f3;
    int v;
    bit isLw, isSw, isR, isI, isBeq;
    p = '0;
    op = ins[6:0];
    f3 = int'(ins[14:12]);
    isLw = (op == 7'h03);
    isSw = (op == 7'h23);
    isR = (op == 7'h33);
    isI = (op == 7'h13);
    isBeq = (op == 7'h63);
    p.regWrite = isLw | isR | isI;
    p.resultSrc = isLw;
    p.memWrite = isSw;
    p.branch = isBeq;
    p.aluSrc = isLw | isSw | isI;
    if (isR || isI) begin
      case (f3)
        0: p.aluCtl = (isR && ins[30]) ? 3'd1 : 3'd0;
        2: p.aluCtl = 3'd5;
        6: p.aluCtl = 3'd3;
        7: p.aluCtl = 3'd2;
        default: p.aluCtl = 3'd0;
      endcase
    end else if (isBeq) begin
      p.aluCtl = 3'd1;
    end
    v = 0;
    if (isLw || isI) v = $signed(ins[31:20]);
    else if (isSw) v = $signed({ins[31:25], ins[11:7]});
    else if (isBeq) v = $signed({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
    p.imm = v;
    if (flush) begin
      p.regWrite = 0; p.resultSrc = 0; p.memWrite = 0; p.branch = 0; p.aluSrc = 0;
      p.aluCtl = 0;
    end
    p.rd1 = modelRead(ins[19:15], wEn, wAddr, wData);
    p.rd2 = modelRead(ins[24:20], wEn, wAddr, wData);
    p.rs1 = ins[19:15];
    p.rs2 = ins[24:20];
    p.rd = ins[11:7];
    p.pc = pc;
    p.pcPlus4 = pcp4;
    return p;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      expQ = '0;
      for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
    end else begin
      expQ = predict(InstrD, PCD, PCPlus4D, FlushE, RegWriteW, RDW, ResultW);
      if (RegWriteW && RDW != 5'd0) mRegs[RDW] = ResultW;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    idex_t e;
    e = rst ? expQ : '0;
    checkOutput("RegWriteE", 32'(RegWriteE), 32'(e.regWrite));
    checkOutput("ResultSrcE", 32'(ResultSrcE), 32'(e.resultSrc));
    checkOutput("MemWriteE", 32'(MemWriteE), 32'(e.memWrite));
    checkOutput("BranchE", 32'(BranchE), 32'(e.branch));
    checkOutput("ALUSrcE", 32'(ALUSrcE), 32'(e.aluSrc));
    checkOutput("ALUControlE", 32'(ALUControlE), 32'(e.aluCtl));
    checkOutput("RD1E", RD1E, e.rd1);
    checkOutput("RD2E", RD2E, e.rd2);
    checkOutput("ImmExtE", ImmExtE, e.imm);
    checkOutput("RS1E", 32'(RS1E), 32'(e.rs1));
    checkOutput("RS2E", 32'(RS2E), 32'(e.rs2));
    checkOutput("RDE", 32'(RDE), 32'(e.rd));
    checkOutput("PCE", PCE, e.pc);
    checkOutput("PCPlus4E", PCPlus4E, e.pcPlus4);
  end

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input logic wEn, input logic [4:0] wAddr,
                               input logic [31:0] wData, input logic flush);
    @(negedge clk);
    #1;
    InstrD = ins;
    PCD = pc;
    PCPlus4D = pc + 32'd4;
    RegWriteW = wEn;
    RDW = wAddr;
    ResultW = wData;
    FlushE = flush;
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] r;
  logic [31:0] ins;
  logic [6:0]  ops [6];

  initial begin
    $display("[TB] decode_cycle bench start");
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h00;

    InstrD = 32'h00500093;
    repeat (2) afterEdge();
    checkOutput("rst RegWriteE", 32'(RegWriteE), 32'h0);
    checkOutput("rst ImmExtE", ImmExtE, 32'h0);
    checkOutput("rst RDE", 32'(RDE), 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    afterEdge();
    checkOutput("addi RegWriteE", 32'(RegWriteE), 32'h1);
    checkOutput("addi ALUSrcE", 32'(ALUSrcE), 32'h1);
    checkOutput("addi ALUControlE", 32'(ALUControlE), 32'h0);
    checkOutput("addi ImmExtE", ImmExtE, 32'h5);
    checkOutput("addi RDE", 32'(RDE), 32'h1);
    checkOutput("addi RD1E", RD1E, 32'h0);

    applyStimulus(32'h002101B3, 32'h4, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0);
    afterEdge();
    checkOutput("bypass RD1E", RD1E, 32'hDEADBEEF);
    checkOutput("bypass RD2E", RD2E, 32'hDEADBEEF);
    checkOutput("add ALUControlE", 32'(ALUControlE), 32'h0);
    checkOutput("add RDE", 32'(RDE), 32'h3);

    applyStimulus(32'h00000033, 32'h8, 1'b1, 5'd0, 32'h1234, 1'b0);
    afterEdge();
    checkOutput("x0 bypass RD1E", RD1E, 32'h0);
    applyStimulus(32'h00000033, 32'hC, 1'b0, 5'd0, 32'h0, 1'b0);
    afterEdge();
    checkOutput("x0 RD1E", RD1E, 32'h0);
    checkOutput("x0 RD2E", RD2E, 32'h0);
    checkOutput("x0 RegWriteE", 32'(RegWriteE), 32'h1);

    applyStimulus(32'h00532423, 32'h10, 1'b0, 5'd0, 32'h0, 1'b0);
    afterEdge();
    checkOutput("sw MemWriteE", 32'(MemWriteE), 32'h1);
    checkOutput("sw RegWriteE", 32'(RegWriteE), 32'h0);
    checkOutput("sw ALUSrcE", 32'(ALUSrcE), 32'h1);
    checkOutput("sw ImmExtE", ImmExtE, 32'h8);
    checkOutput("sw RS1E", 32'(RS1E), 32'h6);
    checkOutput("sw RS2E", 32'(RS2E), 32'h5);

    applyStimulus(32'hFE208EE3, 32'h40, 1'b0, 5'd0, 32'h0, 1'b0);
    afterEdge();
    checkOutput("beq BranchE", 32'(BranchE), 32'h1);
    checkOutput("beq ALUControlE", 32'(ALUControlE), 32'h1);
    checkOutput("beq ImmExtE", ImmExtE, 32'hFFFFFFFC);
    checkOutput("beq PCE", PCE, 32'h40);
    checkOutput("beq PCPlus4E", PCPlus4E, 32'h44);
    applyStimulus(32'hFE208EE3, 32'h40, 1'b0, 5'd0, 32'h0, 1'b1);
    afterEdge();
    checkOutput("flush BranchE", 32'(BranchE), 32'h0);
    checkOutput("flush ALUControlE", 32'(ALUControlE), 32'h0);
    checkOutput("flush ImmExtE", ImmExtE, 32'hFFFFFFFC);
    checkOutput("flush PCE", PCE, 32'h40);

    applyStimulus(32'h00000013, 32'h48, 1'b1, 5'd5, 32'h77, 1'b0);
    applyStimulus(32'h00028093, 32'h4C, 1'b0, 5'd0, 32'h0, 1'b0);
    afterEdge();
    checkOutput("x5 RD1E", RD1E, 32'h77);
    @(negedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("midrst RD1E", RD1E, 32'h0);
    checkOutput("midrst RegWriteE", 32'(RegWriteE), 32'h0);
    afterEdge();
    checkOutput("midrst PCE", PCE, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    afterEdge();
    checkOutput("postrst x5 RD1E", RD1E, 32'h0);
    checkOutput("postrst RegWriteE", 32'(RegWriteE), 32'h1);

    for (int n = 0; n < 500; n++) begin
      r = $urandom();
      ins = {r[31:7], ops[$urandom_range(0, 5)]};
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom());
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      applyStimulus(ins, {$urandom_range(0, 32'h3FFF), 2'b00}, 1'($urandom()),
                    5'($urandom_range(0, 7)), $urandom(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 63) == 0) begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
Name: decode_cycle

Overview:
- Decode stage of the 5-stage RV32I pipeline. It is the receiving end of the IF/ID interface (InstrD, PCD, PCPlus4D).
- Decodes the instruction, generates control signals and the sign-extended immediate, and reads the 32x32 register file.
- Writeback drives the register file write port.
- The ID/EX pipeline register is inside this block. Its outputs feed the execute stage and the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register file depth; register x0 is hardwired to 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback write enable
- RDW  in  5  writeback destination register
- ResultW  in  32  writeback data
- FlushE  in  1  squash the instruction entering EX (taken branch)
- RegWriteE  out  1  register write enable
- ResultSrcE  out  1  1 = memory load result
- MemWriteE  out  1  store enable
- BranchE  out  1  beq
- ALUSrcE  out  1  1 = immediate operand
- ALUControlE  out  3  ALU operation
- RD1E  out  32  rs1 data
- RD2E  out  32  rs2 data
- ImmExtE  out  32  sign-extended immediate
- RS1E  out  5  rs1 index
- RS2E  out  5  rs2 index
- RDE  out  5  rd index
- PCE  out  32  registered PCD
- PCPlus4E  out  32  registered PCPlus4D

Behaviour:
- Reset: rst is asynchronous and active-low; clock is clk.
  - While rst=0, every output is 0 (combinational gate plus asynchronous register clear).
  - All 31 writable registers clear to 0.
  - Reset applied mid-operation discards the in-flight ID/EX contents.
- Latency: every output updates one clk edge after InstrD/PCD/PCPlus4D are presented. No stall; the register loads every cycle.
- Register file:
  - Write on posedge clk when RegWriteW=1 and RDW!=0.
  - Writes with RDW=0 are ignored; x0 always reads 0.
  - Read is combinational on InstrD[19:15] and InstrD[24:20].
  - Write-first bypass: if RegWriteW=1, RDW!=0 and RDW equals a read index in the same cycle, that read returns ResultW.
- Main decoder (opcode InstrD[6:0]):
  - 0000011 lw: RegWrite=1, ResultSrc=1, ALUSrc=1, ImmSrc=I, ALUOp=00.
  - 0100011 sw: MemWrite=1, ALUSrc=1, ImmSrc=S, ALUOp=00.
  - 0110011 R-type: RegWrite=1, ALUOp=10.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, ImmSrc=I, ALUOp=10.
  - 1100011 beq: Branch=1, ImmSrc=B, ALUOp=01.
  - Any other opcode: all controls 0 (bubble).
- ALU decoder:
  - ALUOp=00 gives 000 (add).
  - ALUOp=01 gives 001 (sub).
  - ALUOp=10 uses funct3:
    - 000: 001 (sub) if R-type and InstrD[30]=1, else 000.
    - 010: 101 (slt).
    - 110: 011 (or).
    - 111: 010 (and).
    - Any other funct3: 000.
- Immediate extension:
  - I = sext(InstrD[31:20]).
  - S = sext({InstrD[31:25], InstrD[11:7]}).
  - B = sext({InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0}).
  - Unused types produce 0.
- Flush: FlushE=1 at an edge loads RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE and ALUControlE as 0. The data, index and PC fields still load normally.
- RS1E, RS2E and RDE are loaded from InstrD[19:15], [24:20] and [11:7] regardless of instruction type.

Test Plan:
1. Hold rst=0 with InstrD=0x00500093 -> all outputs 0. Release rst; after one edge -> RegWriteE=1, ALUSrcE=1, ALUControlE=000, ImmExtE=0x00000005, RDE=1, RD1E=0.
2. InstrD=0x002101B3 (add x3,x2,x2) in the same cycle as RegWriteW=1, RDW=2, ResultW=0xDEADBEEF -> RD1E=RD2E=0xDEADBEEF, ALUControlE=000, RDE=3.
3. Write RDW=0, ResultW=0x1234, then InstrD=0x00000033 -> RD1E=RD2E=0; RegWriteE=1.
4. InstrD=0x00532423 (sw x5,8(x6)) -> MemWriteE=1, RegWriteE=0, ALUSrcE=1, ImmExtE=0x00000008, RS1E=6, RS2E=5.
5. InstrD=0xFE208EE3 (beq x1,x2,-4), PCD=0x40 -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, PCE=0x40, PCPlus4E=0x44. The same instruction with FlushE=1 -> all controls 0 and PCE=0x40.
6. Load x5=0x77, then assert rst=0 mid-stream and release; read x5 -> RD1E=0; outputs were 0 throughout reset.
